cross_bar_arbiter_rr_mx1: RTL and testbench
===========================================

Name: cross_bar_arbiter_rr_mx1

Overview:
- Next-generation M-to-1 AXI-Stream arbiter for the cross-bar output ports.
- Work-conserving round-robin: idle channels are skipped, and a new grant is issued on the same cycle the previous packet's last beat is accepted.
- Supports any channel count (not limited to powers of two), a packet or per-beat arbitration mode, tkeep/tid sideband, and an optional registered output slice for timing closure.

Parameters:
CHANNEL_NO, 4, number of slave channels, >=2, any integer
SEL_WIDTH, $clog2(CHANNEL_NO), width of channel index / tid
DATA_WIDTH, 32, tdata width in bits, multiple of 8
KEEP_WIDTH, DATA_WIDTH/8, tkeep width
PACKET_MODE, 1, 1: grant held until tlast handshake; 0: re-arbitrate after every accepted beat
REG_OUTPUT, 1, 1: master side driven through a 2-entry skid buffer; 0: combinational pass-through

Ports:
aclk  in  1  clock; all logic on rising edge
aresetn  in  1  reset, asynchronous, active-low
s_axis_tdata  in  DATA_WIDTH x CHANNEL_NO  slave data
s_axis_tkeep  in  KEEP_WIDTH x CHANNEL_NO  slave byte enables
s_axis_tvalid  in  1 x CHANNEL_NO  slave valid
s_axis_tlast  in  1 x CHANNEL_NO  slave end of packet
s_axis_tready  out  1 x CHANNEL_NO  slave ready
m_axis_tdata  out  DATA_WIDTH  master data
m_axis_tkeep  out  KEEP_WIDTH  master byte enables
m_axis_tid  out  SEL_WIDTH  index of the source channel of this beat
m_axis_tvalid  out  1  master valid
m_axis_tlast  out  1  master end of packet
m_axis_tready  in  1  master ready
grant_active  out  1  a channel currently holds the grant
grant_idx  out  SEL_WIDTH  currently or last granted channel

Behaviour:
- Reset: when aresetn is low, reset applies immediately without waiting for a clock edge. Reset values: state=IDLE, grant_idx=CHANNEL_NO-1 (channel 0 therefore has highest priority first), grant_active=0, all s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata/tkeep/tid=0, skid buffer emptied. Reset release is synchronous to aclk; this is guaranteed by the upstream reset synchroniser.
- Reset mid-packet: the partial packet is discarded. There is no recovery and no replay.
- Request vector: req[i]=s_axis_tvalid[i].
- Arbitration: select the first i with req[i]=1, scanning (grant_idx+1) mod CHANNEL_NO upward and wrapping at CHANNEL_NO-1 to 0. Indices >= CHANNEL_NO are never produced.
- States:
  - IDLE: if any req, register the winner into grant_idx and go to ACTIVE. Otherwise stay, and the pointer is unchanged.
  - ACTIVE: s_axis_tready[grant_idx] = internal ready; all other s_axis_tready=0. Internal valid/data/keep/last are taken from channel grant_idx, and tid=grant_idx.
- Release of the grant:
  - PACKET_MODE=1: on a beat handshake with tlast=1.
  - PACKET_MODE=0: on every beat handshake.
  - On release, if any req is present excluding the releasing channel's current beat, the next winner is computed from the updated pointer and loaded the same cycle; state stays ACTIVE (zero bubble).
  - The releasing channel may re-win only if no other channel is requesting.
  - Otherwise go to IDLE.
- Latency:
  - IDLE to first s_axis_tready: 1 cycle.
  - Source beat to m_axis output: 0 cycles with REG_OUTPUT=0, 1 cycle with REG_OUTPUT=1.
- Throughput: 1 beat/cycle sustained under continuous m_axis_tready, including across packet boundaries.
- Grant hold in PACKET_MODE=1: the grant is held regardless of tvalid gaps from the owning channel. Other channels wait.
- Skid buffer (REG_OUTPUT=1):
  - Internal ready = buffer not full; this is registered, so there is no combinational path from m_axis_tready.
  - Full: both entries occupied; internal ready=0.
  - Empty: m_axis_tvalid=0.
  - Simultaneous push and pop while holding 1 entry: occupancy stays at 1.
  - Beats are never dropped or duplicated.
- grant_active=1 exactly in ACTIVE.

Decomposition:
- Package cross_bar_pkg:
  - state_type enum {IDLE, ACTIVE}.
  - Function rr_next(req, ptr, n) returning the round-robin winner index and a found flag.
- Sub-module axis_skid_buffer, parameters DATA_WIDTH/KEEP_WIDTH/ID_WIDTH:
  - Instantiated when REG_OUTPUT=1; generate bypass otherwise.
  - Used by other crossbar blocks too.

Test Plan:
- Reset: drive aresetn low mid-packet between clock edges -> m_axis_tvalid and all s_axis_tready go to 0 before the next edge. After release, with all 4 channels valid, channel 0 is granted first (tid=0).
- Fairness, no bubble (CHANNEL_NO=4, PACKET_MODE=1, m_axis_tready=1): all channels send continuous 2-beat packets -> tid sequence 0,0,1,1,2,2,3,3,0,0, with 8 consecutive m_axis beats per round and no idle cycle.
- Skip idle channels: only channels 0 and 2 valid, pointer at 0 -> grant 2 next (channel 1 skipped), then 0. tid pattern 2,0,2,0 per packet.
- Backpressure: m_axis_tready pseudo-random at 50%, 1000 beats from 4 channels -> per-channel payload order preserved, no loss or duplication, and a packet is never interleaved in PACKET_MODE=1.
- PACKET_MODE=0: channels 1 and 3 each send a 3-beat packet together -> beats alternate tid 1,3,1,3,1,3, with tlast on beats 5 and 6.
- CHANNEL_NO=3 (SEL_WIDTH=2): all valid, single-beat packets -> tid 0,1,2,0,1,2. Value 3 never appears on tid or grant_idx.

Source files
------------

// File: rtl/cross_bar_pkg.sv
// cross_bar_pkg: shared arbiter state type and round-robin winner search
// Contents:
//   state_type  - arbiter FSM states
//   MAX_CH      - widest request vector rr_next accepts
//   rr_result_t - winner index plus found flag
//   rr_next     - first requester after ptr, scanning upward and wrapping at n-1
package cross_bar_pkg;
   typedef enum logic {IDLE, ACTIVE} state_type;
   localparam int MAX_CH = 32;
   typedef struct packed {
      logic       found;
      logic [7:0] idx;
   } rr_result_t;
   function automatic rr_result_t rr_next(input logic [MAX_CH-1:0] req, input int ptr, input int n);
      rr_result_t r;
      int c;
      r = '0;
      for (int k = 1; k <= MAX_CH; k++) begin
         c = (ptr + k) % n;
         if (k <= n && !r.found && req[c]) begin
            r.found = 1'b1;
            r.idx = 8'(c);
         end
      end
      return r;
   endfunction
endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: 2-entry AXI-Stream register slice
// Ports:
//   aclk, aresetn                 - clock, async active-low reset
//   s_tdata/tkeep/tid/tlast/tvalid - upstream beat, s_tready = buffer not full
//   m_tdata/tkeep/tid/tlast/tvalid - downstream beat, m_tready from sink
// s_tready decodes registered occupancy only, so there is no
// combinational path from m_tready back to the upstream side.
module axis_skid_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int KEEP_WIDTH = 4,
   parameter int ID_WIDTH   = 2
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [DATA_WIDTH-1:0] s_tdata,
   input  logic [KEEP_WIDTH-1:0] s_tkeep,
   input  logic [ID_WIDTH-1:0]   s_tid,
   input  logic                  s_tlast,
   input  logic                  s_tvalid,
   output logic                  s_tready,
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic [KEEP_WIDTH-1:0] m_tkeep,
   output logic [ID_WIDTH-1:0]   m_tid,
   output logic                  m_tlast,
   output logic                  m_tvalid,
   input  logic                  m_tready
);
   localparam int W = DATA_WIDTH + KEEP_WIDTH + ID_WIDTH + 1;
   logic [W-1:0] mem [2];
   logic         rd_ptr, wr_ptr, push, pop;
   logic [1:0]   count;
   assign s_tready = count != 2'd2;
   assign m_tvalid = count != 2'd0;
   assign push = s_tvalid && s_tready;
   assign pop = m_tvalid && m_tready;
   assign {m_tdata, m_tkeep, m_tid, m_tlast} = mem[rd_ptr];
   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) begin
         mem[0] <= '0;
         mem[1] <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= {s_tdata, s_tkeep, s_tid, s_tlast};
            wr_ptr <= !wr_ptr;
         end
         if (pop) rd_ptr <= !rd_ptr;
         count <= count + 2'(push) - 2'(pop);
      end
endmodule

// File: rtl/cross_bar_arbiter_rr_mx1.sv
// cross_bar_arbiter_rr_mx1: work-conserving round-robin M-to-1 AXI-Stream arbiter
// Ports:
//   aclk, aresetn        - clock, async active-low reset
//   s_axis_*             - CHANNEL_NO packed slave streams (tdata/tkeep/tvalid/tlast/tready)
//   m_axis_*             - merged master stream, tid = source channel
//   grant_active         - a channel holds the grant
//   grant_idx            - current or last granted channel (round-robin pointer)
module cross_bar_arbiter_rr_mx1
   import cross_bar_pkg::*;
#(
   parameter int CHANNEL_NO  = 4,
   parameter int SEL_WIDTH   = $clog2(CHANNEL_NO),
   parameter int DATA_WIDTH  = 32,
   parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
   parameter int PACKET_MODE = 1,
   parameter int REG_OUTPUT  = 1
) (
   input  logic                             aclk,
   input  logic                             aresetn,
   input  logic [DATA_WIDTH*CHANNEL_NO-1:0] s_axis_tdata,
   input  logic [KEEP_WIDTH*CHANNEL_NO-1:0] s_axis_tkeep,
   input  logic [CHANNEL_NO-1:0]            s_axis_tvalid,
   input  logic [CHANNEL_NO-1:0]            s_axis_tlast,
   output logic [CHANNEL_NO-1:0]            s_axis_tready,
   output logic [DATA_WIDTH-1:0]            m_axis_tdata,
   output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
   output logic [SEL_WIDTH-1:0]             m_axis_tid,
   output logic                             m_axis_tvalid,
   output logic                             m_axis_tlast,
   input  logic                             m_axis_tready,
   output logic                             grant_active,
   output logic [SEL_WIDTH-1:0]             grant_idx
);
   state_type             state, state_next;
   logic [SEL_WIDTH-1:0]  grant_next, i_tid;
   logic [MAX_CH-1:0]     req_all, req_excl;
   rr_result_t            win_all, win_excl;
   logic [DATA_WIDTH-1:0] i_data;
   logic [KEEP_WIDTH-1:0] i_keep;
   logic                  i_valid, i_last, i_ready, release_g;
   assign grant_active = state == ACTIVE;
   assign i_tid = grant_active ? grant_idx : '0;
   always_comb begin
      req_all = '0;
      req_all[CHANNEL_NO-1:0] = s_axis_tvalid;
      req_excl = req_all;
      i_data = '0;
      i_keep = '0;
      i_valid = 1'b0;
      i_last = 1'b0;
      s_axis_tready = '0;
      for (int i = 0; i < CHANNEL_NO; i++)
         if (grant_active && grant_idx == SEL_WIDTH'(i)) begin
            i_valid = s_axis_tvalid[i];
            i_last = s_axis_tlast[i];
            i_data = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            i_keep = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
            s_axis_tready[i] = i_ready;
            req_excl[i] = 1'b0;
         end
      // The releasing channel is masked out so it can only re-win via IDLE,
      // i.e. when nobody else is requesting.
      win_all = rr_next(req_all, int'(grant_idx), CHANNEL_NO);
      win_excl = rr_next(req_excl, int'(grant_idx), CHANNEL_NO);
      release_g = i_valid && i_ready && (PACKET_MODE != 0 ? i_last : 1'b1);
      state_next = state;
      grant_next = grant_idx;
      for (int i = 0; i < CHANNEL_NO; i++) begin
         if (!grant_active && win_all.found && win_all.idx == 8'(i)) begin
            state_next = ACTIVE;
            grant_next = SEL_WIDTH'(i);
         end
         if (release_g && win_excl.found && win_excl.idx == 8'(i)) grant_next = SEL_WIDTH'(i);
      end
      if (release_g && !win_excl.found) state_next = IDLE;
   end
   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) begin
         state <= IDLE;
         grant_idx <= SEL_WIDTH'(CHANNEL_NO - 1);
      end else begin
         state <= state_next;
         grant_idx <= grant_next;
      end
   if (REG_OUTPUT != 0) begin : g_reg
      axis_skid_buffer #(
         .DATA_WIDTH(DATA_WIDTH),
         .KEEP_WIDTH(KEEP_WIDTH),
         .ID_WIDTH  (SEL_WIDTH)
      ) u_skid (
         .aclk    (aclk),
         .aresetn (aresetn),
         .s_tdata (i_data),
         .s_tkeep (i_keep),
         .s_tid   (i_tid),
         .s_tlast (i_last),
         .s_tvalid(i_valid),
         .s_tready(i_ready),
         .m_tdata (m_axis_tdata),
         .m_tkeep (m_axis_tkeep),
         .m_tid   (m_axis_tid),
         .m_tlast (m_axis_tlast),
         .m_tvalid(m_axis_tvalid),
         .m_tready(m_axis_tready)
      );
   end else begin : g_bypass
      assign m_axis_tdata = i_data;
      assign m_axis_tkeep = i_keep;
      assign m_axis_tid = i_tid;
      assign m_axis_tlast = i_last;
      assign m_axis_tvalid = i_valid;
      assign i_ready = m_axis_tready;
   end
endmodule

// File: tb/tb_cross_bar_arbiter_rr_mx1.sv
// tb_cross_bar_arbiter_rr_mx1: self-checking bench for the round-robin stream arbiter
module tb_cross_bar_arbiter_rr_mx1;
   logic aclk = 1'b0, aresetn = 1'b0;
   always #5 aclk = ~aclk;

   // u0: 4 channels, packet mode, registered output
   logic [127:0] s0_data = '0;
   logic [15:0]  s0_keep = '0;
   logic [3:0]   s0_valid = '0, s0_last = '0, s0_ready;
   logic [31:0]  m0_data;
   logic [3:0]   m0_keep;
   logic [1:0]   m0_tid, g0_idx;
   logic         m0_valid, m0_last, m0_ready = 1'b1, g0_act;
   // u1: 4 channels, per-beat mode, pass-through output
   logic [127:0] s1_data = '0;
   logic [15:0]  s1_keep = '0;
   logic [3:0]   s1_valid = '0, s1_last = '0, s1_ready;
   logic [31:0]  m1_data;
   logic [3:0]   m1_keep;
   logic [1:0]   m1_tid, g1_idx;
   logic         m1_valid, m1_last, m1_ready = 1'b1, g1_act;
   // u2: 3 channels, packet mode, registered output
   logic [95:0]  s2_data = '0;
   logic [11:0]  s2_keep = '0;
   logic [2:0]   s2_valid = '0, s2_last = '0, s2_ready;
   logic [31:0]  m2_data;
   logic [3:0]   m2_keep;
   logic [1:0]   m2_tid, g2_idx;
   logic         m2_valid, m2_last, m2_ready = 1'b1, g2_act;

   cross_bar_arbiter_rr_mx1 #(.CHANNEL_NO(4), .PACKET_MODE(1), .REG_OUTPUT(1)) u0 (
      .aclk(aclk), .aresetn(aresetn), .s_axis_tdata(s0_data), .s_axis_tkeep(s0_keep),
      .s_axis_tvalid(s0_valid), .s_axis_tlast(s0_last), .s_axis_tready(s0_ready),
      .m_axis_tdata(m0_data), .m_axis_tkeep(m0_keep), .m_axis_tid(m0_tid), .m_axis_tvalid(m0_valid),
      .m_axis_tlast(m0_last), .m_axis_tready(m0_ready), .grant_active(g0_act), .grant_idx(g0_idx));
   cross_bar_arbiter_rr_mx1 #(.CHANNEL_NO(4), .PACKET_MODE(0), .REG_OUTPUT(0)) u1 (
      .aclk(aclk), .aresetn(aresetn), .s_axis_tdata(s1_data), .s_axis_tkeep(s1_keep),
      .s_axis_tvalid(s1_valid), .s_axis_tlast(s1_last), .s_axis_tready(s1_ready),
      .m_axis_tdata(m1_data), .m_axis_tkeep(m1_keep), .m_axis_tid(m1_tid), .m_axis_tvalid(m1_valid),
      .m_axis_tlast(m1_last), .m_axis_tready(m1_ready), .grant_active(g1_act), .grant_idx(g1_idx));
   cross_bar_arbiter_rr_mx1 #(.CHANNEL_NO(3), .PACKET_MODE(1), .REG_OUTPUT(1)) u2 (
      .aclk(aclk), .aresetn(aresetn), .s_axis_tdata(s2_data), .s_axis_tkeep(s2_keep),
      .s_axis_tvalid(s2_valid), .s_axis_tlast(s2_last), .s_axis_tready(s2_ready),
      .m_axis_tdata(m2_data), .m_axis_tkeep(m2_keep), .m_axis_tid(m2_tid), .m_axis_tvalid(m2_valid),
      .m_axis_tlast(m2_last), .m_axis_tready(m2_ready), .grant_active(g2_act), .grant_idx(g2_idx));

   typedef struct packed { logic [31:0] data; logic last; } beat_t;
   typedef struct { int tid; logic [31:0] data; logic [3:0] keep; logic last; int cyc; } mon_t;
   typedef struct { logic [3:0] mask; int len; int npk; bit nobub; string exp; } vec_t;

   beat_t src_q[4][$];
   mon_t  mon_q[$];
   int    seq_sent[4];
   logic  [3:0] taken = '0;
   bit    rand_gap = 0, rand_rdy = 0;
   int    cyc = 0, n_tests = 0, n_fail = 0;
   vec_t  vecs[7];

   function automatic logic [3:0] kfn(input logic [31:0] d);
      return d[3:0] ^ d[27:24];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // source driver for u0: holds an offered beat until it is taken
   initial begin : drv
      logic held;
      forever begin
         @(posedge aclk);
         #1;
         cyc++;
         for (int i = 0; i < 4; i++) begin
            held = s0_valid[i] && !taken[i];
            s0_valid[i] = src_q[i].size() > 0 && (held || !rand_gap || $urandom_range(3) != 0);
            if (src_q[i].size() > 0) begin
               s0_data[i*32 +: 32] = src_q[i][0].data;
               s0_keep[i*4 +: 4] = kfn(src_q[i][0].data);
               s0_last[i] = src_q[i][0].last;
            end
            taken[i] = 1'b0;
         end
         m0_ready = rand_rdy ? 1'($urandom_range(1)) : 1'b1;
      end
   end

   // handshake monitor for u0
   initial forever begin
      @(negedge aclk);
      if (aresetn) begin
         for (int i = 0; i < 4; i++)
            if (s0_valid[i] && s0_ready[i]) begin
               src_q[i].delete(0);
               taken[i] = 1'b1;
            end
         if (m0_valid && m0_ready) mon_q.push_back('{int'(m0_tid), m0_data, m0_keep, m0_last, cyc});
      end
   end

   task automatic flush();
      for (int i = 0; i < 4; i++) begin
         src_q[i].delete();
         seq_sent[i] = 0;
      end
      mon_q.delete();
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      flush();
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;
   endtask

   task automatic load_pkt(input int ch, input int len);
      beat_t b;
      for (int k = 0; k < len; k++) begin
         b.data = {8'(ch), 24'(seq_sent[ch])};
         b.last = k == len - 1;
         src_q[ch].push_back(b);
         seq_sent[ch]++;
      end
   endtask

   task automatic wait_drain(input string name, input int limit);
      int t = 0;
      while ((src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size() > 0 || m0_valid) && t < limit) begin
         @(negedge aclk);
         t++;
      end
      repeat (2) @(negedge aclk);
      check({name, " drain in budget"}, 32'(t < limit), 32'd1);
   endtask

   // reference properties: tid names the payload's source, per-channel
   // payload order is contiguous, keep follows data, packets never interleave
   task automatic check_stream(input string name, input int exp_beats);
      int nxt[4], cnt[4], ch, prev_tid;
      logic prev_last;
      nxt = '{default: 0};
      cnt = '{default: 0};
      prev_last = 1'b1;
      prev_tid = 0;
      check({name, " beat count"}, 32'(mon_q.size()), 32'(exp_beats));
      for (int k = 0; k < mon_q.size(); k++) begin
         ch = int'(mon_q[k].data[25:24]);
         check({name, " tid vs source"}, 32'(mon_q[k].tid), 32'(mon_q[k].data[31:24]));
         check({name, " order"}, 32'(mon_q[k].data[23:0]), 32'(nxt[ch]));
         check({name, " tkeep"}, 32'(mon_q[k].keep), 32'(kfn(mon_q[k].data)));
         if (!prev_last) check({name, " no interleave"}, 32'(mon_q[k].tid), 32'(prev_tid));
         nxt[ch] = int'(mon_q[k].data[23:0]) + 1;
         cnt[ch]++;
         prev_last = mon_q[k].last;
         prev_tid = mon_q[k].tid;
      end
      for (int i = 0; i < 4; i++) check($sformatf("%s ch%0d delivered", name, i), 32'(cnt[i]), 32'(seq_sent[i]));
   endtask

   task automatic test_pm0();
      int sent[4];
      logic [1:0] tids[$];
      logic lasts[$];
      logic [31:0] datas[$];
      string exp_t = "131313";
      sent = '{default: 0};
      s1_valid = 4'b1010;
      s1_last = '0;
      s1_data = '0;
      s1_data[63:32] = {8'd1, 24'd0};
      s1_data[127:96] = {8'd3, 24'd0};
      for (int t = 0; t < 40 && tids.size() < 6; t++) begin
         @(negedge aclk);
         if (m1_valid && m1_ready) begin
            tids.push_back(m1_tid);
            lasts.push_back(m1_last);
            datas.push_back(m1_data);
         end
         for (int c = 1; c < 4; c += 2) if (s1_valid[c] && s1_ready[c]) sent[c]++;
         @(posedge aclk);
         #1;
         for (int c = 1; c < 4; c += 2) begin
            s1_valid[c] = sent[c] < 3;
            s1_last[c] = sent[c] == 2;
            s1_data[c*32 +: 32] = {8'(c), 24'(sent[c])};
         end
      end
      check("pm0 beat count", 32'(tids.size()), 32'd6);
      for (int k = 0; k < tids.size(); k++) begin
         check($sformatf("pm0 tid beat%0d", k + 1), 32'(tids[k]), 32'(int'(exp_t[k]) - 48));
         check($sformatf("pm0 tlast beat%0d", k + 1), 32'(lasts[k]), 32'(k >= 4));
         check($sformatf("pm0 data beat%0d", k + 1), datas[k], {8'(int'(exp_t[k]) - 48), 24'(k / 2)});
      end
      s1_valid = '0;
   endtask

   task automatic test_ch3();
      logic [1:0] tids[$];
      s2_data = {32'd2, 32'd1, 32'd0};
      s2_keep = '1;
      s2_last = 3'b111;
      s2_valid = 3'b111;
      for (int t = 0; t < 40 && tids.size() < 6; t++) begin
         @(negedge aclk);
         check("ch3 grant_idx in range", 32'(g2_idx < 2'd3), 32'd1);
         if (m2_valid && m2_ready) begin
            tids.push_back(m2_tid);
            check("ch3 data follows tid", m2_data, 32'(m2_tid));
         end
      end
      check("ch3 beat count", 32'(tids.size()), 32'd6);
      for (int k = 0; k < tids.size(); k++) check($sformatf("ch3 tid beat%0d", k), 32'(tids[k]), 32'(k % 3));
      s2_valid = '0;
   endtask

   initial begin
      vecs[0] = '{4'b1111, 2, 2, 1'b1, "0011223300112233"};
      vecs[1] = '{4'b0101, 2, 2, 1'b0, "00220022"};
      vecs[2] = '{4'b1010, 3, 1, 1'b0, "111333"};
      vecs[3] = '{4'b1000, 2, 2, 1'b0, "3333"};
      vecs[4] = '{4'b0110, 1, 3, 1'b0, "121212"};
      vecs[5] = '{4'b1001, 1, 2, 1'b0, "0303"};
      vecs[6] = '{4'b0111, 1, 2, 1'b1, "012012"};
      flush();
      repeat (2) @(negedge aclk);
      check("reset grant_idx", 32'(g0_idx), 32'd3);
      check("reset grant_active", 32'(g0_act), 32'd0);
      check("reset m_tvalid", 32'(m0_valid), 32'd0);
      check("reset s_tready", 32'(s0_ready), 32'd0);
      check("reset m_tdata", m0_data, 32'd0);
      check("reset m_tid", 32'(m0_tid), 32'd0);
      check("reset ch3 grant_idx", 32'(g2_idx), 32'd2);
      // IDLE -> first tready in one cycle, source -> m_axis in one cycle
      do_reset();
      load_pkt(2, 1);
      @(negedge aclk);
      check("idle tready low", 32'(s0_ready), 32'd0);
      check("idle grant_active", 32'(g0_act), 32'd0);
      @(negedge aclk);
      check("first tready", 32'(s0_ready), 32'b0100);
      check("first grant_idx", 32'(g0_idx), 32'd2);
      check("first grant_active", 32'(g0_act), 32'd1);
      @(negedge aclk);
      check("out latency valid", 32'(m0_valid), 32'd1);
      check("out latency tid", 32'(m0_tid), 32'd2);
      check("release to idle", 32'(g0_act), 32'd0);
      wait_drain("latency", 100);
      for (int v = 0; v < 7; v++) begin
         string nm;
         nm = $sformatf("vec%0d", v);
         do_reset();
         for (int p = 0; p < vecs[v].npk; p++)
            for (int c = 0; c < 4; c++) if (vecs[v].mask[c]) load_pkt(c, vecs[v].len);
         wait_drain(nm, 500);
         check_stream(nm, vecs[v].exp.len());
         for (int k = 0; k < mon_q.size() && k < vecs[v].exp.len(); k++) begin
            check($sformatf("%s tid%0d", nm, k), 32'(mon_q[k].tid), 32'(int'(vecs[v].exp[k]) - 48));
            check($sformatf("%s tlast%0d", nm, k), 32'(mon_q[k].last), 32'((k % vecs[v].len) == vecs[v].len - 1));
            if (vecs[v].nobub) check($sformatf("%s no bubble%0d", nm, k), 32'(mon_q[k].cyc), 32'(mon_q[0].cyc + k));
         end
      end
      // asynchronous reset in the middle of packets
      do_reset();
      for (int c = 0; c < 4; c++) load_pkt(c, 4);
      repeat (4) @(negedge aclk);
      check("pre-reset m_tvalid", 32'(m0_valid), 32'd1);
      check("pre-reset grant_active", 32'(g0_act), 32'd1);
      #2;
      aresetn = 1'b0;
      #1;
      check("async reset m_tvalid", 32'(m0_valid), 32'd0);
      check("async reset s_tready", 32'(s0_ready), 32'd0);
      check("async reset grant_active", 32'(g0_act), 32'd0);
      check("async reset grant_idx", 32'(g0_idx), 32'd3);
      check("async reset m_tlast", 32'(m0_last), 32'd0);
      flush();
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;
      for (int c = 0; c < 4; c++) load_pkt(c, 1);
      wait_drain("post-reset", 100);
      check_stream("post-reset", 4);
      if (mon_q.size() > 0) check("post-reset first tid", 32'(mon_q[0].tid), 32'd0);
      // randomized backpressure and source gaps
      do_reset();
      rand_gap = 1;
      rand_rdy = 1;
      for (int c = 0; c < 4; c++) while (seq_sent[c] < 250) load_pkt(c, int'($urandom_range(1, 4)));
      wait_drain("random", 20000);
      check_stream("random", seq_sent[0] + seq_sent[1] + seq_sent[2] + seq_sent[3]);
      rand_gap = 0;
      rand_rdy = 0;
      do_reset();
      test_pm0();
      do_reset();
      test_ch3();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
